// File: rtl/prog_mem_loader.sv
// prog_mem_loader: run-time loadable program memory for the K2 8-bit core.
// RUN mode serves registered instruction fetches with one cycle of latency.
// LOAD mode takes a new image over a valid/ready word stream and holds the core.
// Optional feature macro: PROG_MEM_CHECKSUM_EN adds the load_sum checksum port.
//
// Load handshake: a word moves when load_valid and load_ready are both high
// on a rising clk edge. load_ready is high for the whole LOAD state. load_data
// and load_last are only looked at on that edge. load_valid is ignored in RUN.
module prog_mem_loader #(
    parameter int          DATA_W    = 8,
    parameter int          ADDR_W    = 4,
    parameter logic [31:0] FILL_WORD = 32'b0011_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   load_count,
    output logic              load_error,
`ifdef PROG_MEM_CHECKSUM_EN
    output logic [DATA_W-1:0] load_sum,
`endif
    output logic              dbg_state
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] FILL_VAL = DATA_W'(FILL_WORD);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              error_q, error_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              accept;
    logic              room;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    // The count never goes past DEPTH, so its top bit alone marks a full image.
    // The count also serves as the write pointer; it stops at DEPTH instead
    // of wrapping, which keeps overflow words out of the memory.
    assign room    = ~count_q[ADDR_W];
    assign wr_addr = count_q[ADDR_W-1:0];
    assign accept  = load_valid & (state_q == LOAD);

    // Next-state logic for the mode FSM, the load bookkeeping and the fetch port.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        error_d       = error_q;
        fetch_data_d  = fetch_data_q;
        fetch_valid_d = 1'b0;
        wr_en         = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
        sum_d         = sum_q;
`endif
        case (state_q)
            RUN: begin
                if (fetch_en) begin
                    fetch_valid_d = 1'b1;
                    fetch_data_d  = mem_q[fetch_addr];
                end
                if (load_start) begin
                    state_d = LOAD;
                    count_d = '0;
                    error_d = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end
            end
            LOAD: begin
                // A restart wins over a word offered in the same cycle; that word is lost.
                if (load_start) begin
                    count_d = '0;
                    error_d = 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
                    sum_d   = '0;
`endif
                end else if (accept) begin
                    if (room) begin
                        wr_en   = 1'b1;
                        count_d = count_q + 1'b1;
`ifdef PROG_MEM_CHECKSUM_EN
                        sum_d   = sum_q + load_data;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                    if (load_last) begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            count_q       <= '0;
            error_q       <= 1'b0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            error_q       <= error_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
`ifdef PROG_MEM_CHECKSUM_EN
            sum_q         <= sum_d;
`endif
        end
    end

    // Program store: reset refills every word, otherwise only loader writes land.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= FILL_VAL;
            end
        end else if (wr_en) begin
            mem_q[wr_addr] <= load_data;
        end
    end

    assign fetch_data  = fetch_data_q;
    assign fetch_valid = fetch_valid_q;
    assign load_ready  = (state_q == LOAD);
    assign cpu_hold    = (state_q == LOAD);
    assign load_count  = count_q;
    assign load_error  = error_q;
    assign dbg_state   = state_q;
`ifdef PROG_MEM_CHECKSUM_EN
    assign load_sum    = sum_q;
`endif

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed testbench for prog_mem_loader (default 8-bit x 16-word build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_prog_mem_loader;

    logic       clk;
    logic       rst;
    logic       fetch_en;
    logic [3:0] fetch_addr;
    logic [7:0] fetch_data;
    logic       fetch_valid;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_hold;
    logic [4:0] load_count;
    logic       load_error;
    logic       dbg_state;
`ifdef PROG_MEM_CHECKSUM_EN
    logic [7:0] load_sum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    prog_mem_loader dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .fetch_addr  (fetch_addr),
        .fetch_data  (fetch_data),
        .fetch_valid (fetch_valid),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .cpu_hold    (cpu_hold),
        .load_count  (load_count),
        .load_error  (load_error),
`ifdef PROG_MEM_CHECKSUM_EN
        .load_sum    (load_sum),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input logic [3:0] a, input logic [7:0] exp, input string tag);
        fetch_en   = 1'b1;
        fetch_addr = a;
        @(negedge clk);
        fetch_en   = 1'b0;
        check({tag, "_data"}, {24'd0, fetch_data}, {24'd0, exp});
        check({tag, "_valid"}, {31'd0, fetch_valid}, 32'd1);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(negedge clk);
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        fetch_en   = 1'b0;
        fetch_addr = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_fetch_data",  {24'd0, fetch_data}, 32'h0);
        check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("rst_load_ready",  {31'd0, load_ready}, 32'd0);
        check("rst_cpu_hold",    {31'd0, cpu_hold}, 32'd0);
        check("rst_load_count",  {27'd0, load_count}, 32'd0);
        check("rst_load_error",  {31'd0, load_error}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        check("rst_load_sum",    {24'd0, load_sum}, 32'd0);
`endif
        do_fetch(4'd3, 8'h30, "rst_fetch3");
        @(negedge clk);
        check("fetch_valid_drop", {31'd0, fetch_valid}, 32'd0);

        // Short load of three words
        pulse_start();
        check("load_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("load_ready",    {31'd0, load_ready}, 32'd1);
        send_word(8'hC8, 1'b0);
        send_word(8'hFA, 1'b0);
        send_word(8'h20, 1'b1);
        check("l3_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("l3_count",    {27'd0, load_count}, 32'd3);
        check("l3_error",    {31'd0, load_error}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        check("l3_sum",      {24'd0, load_sum}, 32'hE2);
`endif
        do_fetch(4'd1, 8'hFA, "l3_fetch1");
        do_fetch(4'd3, 8'h30, "l3_fetch3");
        do_fetch(4'd0, 8'hC8, "l3_fetch0");
        do_fetch(4'd2, 8'h20, "l3_fetch2");

        // Fetch during LOAD is not served; then overflow with 17 words
        pulse_start();
        fetch_en   = 1'b1;
        fetch_addr = 4'd1;
        @(negedge clk);
        fetch_en   = 1'b0;
        check("hold_fetch_valid", {31'd0, fetch_valid}, 32'd0);
        check("hold_fetch_data",  {24'd0, fetch_data}, 32'h20);
        for (int i = 1; i <= 16; i++) begin
            send_word(8'(i), 1'b0);
        end
        check("full_count", {27'd0, load_count}, 32'd16);
        check("full_error", {31'd0, load_error}, 32'd0);
        check("full_hold",  {31'd0, cpu_hold}, 32'd1);
        send_word(8'h11, 1'b1);
        check("ovf_count", {27'd0, load_count}, 32'd16);
        check("ovf_error", {31'd0, load_error}, 32'd1);
        check("ovf_hold",  {31'd0, cpu_hold}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        check("ovf_sum",   {24'd0, load_sum}, 32'h88);
`endif
        do_fetch(4'd0,  8'h01, "ovf_fetch0");
        do_fetch(4'd15, 8'h10, "ovf_fetch15");
        do_fetch(4'd2,  8'h03, "ovf_fetch2");

        // Restart mid-load; a word offered with the restart is discarded
        pulse_start();
        check("rs_error_clr", {31'd0, load_error}, 32'd0);
        send_word(8'h55, 1'b0);
        send_word(8'h66, 1'b0);
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h77;
        @(negedge clk);
        load_start = 1'b0;
        load_valid = 1'b0;
        check("rs_count_clr", {27'd0, load_count}, 32'd0);
        check("rs_still_hold", {31'd0, cpu_hold}, 32'd1);
        send_word(8'hAA, 1'b1);
        check("rs_count", {27'd0, load_count}, 32'd1);
        check("rs_error", {31'd0, load_error}, 32'd0);
`ifdef PROG_MEM_CHECKSUM_EN
        check("rs_sum",   {24'd0, load_sum}, 32'hAA);
`endif
        do_fetch(4'd0, 8'hAA, "rs_fetch0");
        do_fetch(4'd1, 8'h66, "rs_fetch1");
        do_fetch(4'd2, 8'h03, "rs_fetch2");

        // load_valid in RUN is ignored
        send_word(8'h99, 1'b1);
        check("run_ign_count", {27'd0, load_count}, 32'd1);
        check("run_ign_hold",  {31'd0, cpu_hold}, 32'd0);
        do_fetch(4'd0, 8'hAA, "run_ign_fetch0");

        // Reset in the middle of a load
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_word(8'(8'hE0 + i), 1'b0);
        end
        check("mid_count", {27'd0, load_count}, 32'd5);
        rst = 1'b1;
        #1;
        check("mr_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
        check("mr_load_ready", {31'd0, load_ready}, 32'd0);
        check("mr_count",      {27'd0, load_count}, 32'd0);
        check("mr_fetch_data", {24'd0, fetch_data}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            do_fetch(4'(i), 8'h30, $sformatf("mr_fill%0d", i));
        end
        check("mr_count_after", {27'd0, load_count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Parametrised, run-time loadable program memory for the K2 8-bit core. It replaces a fixed instruction table with a register-array store that serves registered instruction fetches in RUN mode. In LOAD mode it accepts a new program image over a valid/ready byte stream while holding the core via `cpu_hold`. It sits between the core's fetch stage and the host/programming interface.

## Interface
- `DATA_W`, 8, instruction word width in bits
- `ADDR_W`, 4, address width; `DEPTH` = 2**ADDR_W words
- `FILL_WORD`, 8'b0011_0000, content of every word after reset (zero-extended or truncated to DATA_W)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `fetch_en`  in  1  fetch request
- `fetch_addr`  in  ADDR_W  fetch address
- `fetch_data`  out  DATA_W  registered fetch result
- `fetch_valid`  out  1  `fetch_data` holds a fresh word this cycle
- `load_start`  in  1  one-cycle pulse: begin/restart image load
- `load_valid`  in  1  `load_data` valid
- `load_data`  in  DATA_W  image word
- `load_last`  in  1  qualifies final word of image, sampled with `load_valid`
- `load_ready`  out  1  loader accepts a word this cycle
- `cpu_hold`  out  1  core must stall/stay in reset
- `load_count`  out  ADDR_W+1  words written in current/last load
- `load_error`  out  1  sticky overflow flag for current/last load
- `load_sum`  out  DATA_W  running checksum (only with `PROG_MEM_CHECKSUM_EN`)

## Operation
- States: RUN, LOAD. Reset enters RUN.
- Reset values: all words = FILL_WORD; `fetch_data` = 0; `fetch_valid` = 0; `load_ready` = 0; `cpu_hold` = 0; `load_count` = 0; `load_error` = 0; `load_sum` = 0; write pointer = 0.
- RUN: `fetch_data` <= mem[`fetch_addr`] when `fetch_en`, else holds. `fetch_valid` <= `fetch_en`. `load_ready` = 0; `load_valid` is ignored.
- RUN -> LOAD on `load_start`: pointer, `load_count`, `load_error` and `load_sum` cleared on that edge.
- LOAD: `load_ready` = 1 and `cpu_hold` = 1, both decoded from the state register. `fetch_valid` = 0; `fetch_data` holds.
- Accept means `load_valid` & `load_ready`. On accept with `load_count` < DEPTH: mem[pointer] <= `load_data`, pointer++, `load_count`++.
- On accept with `load_count` == DEPTH: word dropped, memory unchanged, pointer does not wrap, `load_error` <= 1.
- Accept with `load_last` -> RUN on the next edge. The final word is written first if there is room.
- `load_start` in LOAD restarts the load: pointer, count, error and sum are cleared. A word accepted in the same cycle is discarded. `load_start` has priority.
- Words not written by a load keep their previous contents.
- Reset mid-load: immediate return to RUN, and the whole array is refilled with FILL_WORD.

## Timing
- Fetch latency: 1 cycle (address at edge N, data/valid after edge N+1).
- A word accepted at edge N is fetchable from the first RUN cycle.
- Earliest fetch after `load_last` accept at edge N: request in cycle after N, data after N+2.
- `cpu_hold` rises the cycle after the `load_start` edge. It falls the cycle after the `load_last` accept edge.
- Throughput: 1 word/cycle in LOAD.

## Configuration
- `PROG_MEM_CHECKSUM_EN` defined:
  - `load_sum` port exists.
  - On every accepted, written word: `load_sum` <= (`load_sum` + `load_data`) mod 2**DATA_W. Dropped words are not summed.
  - Value holds after return to RUN.
- Not defined: `load_sum` port and adder absent; all other behaviour identical.

## Test plan
- Reset, then fetch addr 3 -> `fetch_data` = 0x30, `fetch_valid` = 1 one cycle later. `cpu_hold` = 0, `load_count` = 0.
- `load_start`, then words 0xC8, 0xFA, 0x20 with `load_last` on 0x20:
  - -> `load_count` = 3, `load_error` = 0, RUN resumes.
  - Fetch addr 1 -> 0xFA; addr 3 -> 0x30.
  - With macro: `load_sum` = 0xE2.
- Load 17 words 0x01..0x11, `load_last` on the 17th:
  - -> `load_count` = 16, `load_error` = 1.
  - mem[0] = 0x01, mem[15] = 0x10.
- `load_start` after 2 words, then 1 word 0xAA with `load_last`:
  - -> `load_count` = 1, mem[0] = 0xAA, mem[1] keeps the 2nd word of the aborted load.
- Fetch requested during LOAD -> `fetch_valid` stays 0, `fetch_data` unchanged.
- Assert `rst` after 5 words in LOAD:
  - -> RUN immediately, `cpu_hold` = 0.
  - All words read back 0x30, `load_count` = 0.
